// File: rtl/shake_hand_pkg.sv
// rtl/shake_hand_pkg.sv - shared constants and FSM encoding for the handshake link
package shake_hand_pkg;
  localparam int DEFAULT_DW    = 8;
  localparam int DEFAULT_DEPTH = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SETUP = 2'b01,
    S_HOLD  = 2'b10
  } state_t;
endpackage

// File: rtl/shake_hand_send_if.sv
// rtl/shake_hand_send_if.sv - local push port plus receiver handshake bundle
interface shake_hand_send_if
  import shake_hand_pkg::*;
#(
  parameter int DW = DEFAULT_DW
);
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          ack;
  logic          ready;
  logic [DW-1:0] dout;
  logic          done;

  modport master (
    input  wr_en, wr_data, ack,
    output full, empty, overflow, ready, dout, done
  );

  modport slave (
    output wr_en, wr_data, ack,
    input  full, empty, overflow, ready, dout, done
  );
endinterface

// File: rtl/shake_hand_fifo.sv
// rtl/shake_hand_fifo.sv - small synchronous FIFO with registered flags and sticky overflow
module shake_hand_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_wr_en,
  input  logic [DW-1:0] i_wr_data,
  input  logic          i_rd_en,
  output logic [DW-1:0] o_rd_data,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_overflow
);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [AW:0]   w_count_nxt;
  logic          r_full;
  logic          r_empty;
  logic          r_overflow;
  logic          w_wr_ok;
  logic          w_rd_ok;

  // A write while full is refused even if a pop frees a slot this cycle.
  assign w_wr_ok = i_wr_en && !r_full;
  assign w_rd_ok = i_rd_en && !r_empty;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_ok, w_rd_ok})
      2'b10:   w_count_nxt = r_count + CNT_ONE;
      2'b01:   w_count_nxt = r_count - CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_ok) r_wptr <= r_wptr + PTR_ONE;
      if (w_rd_ok) r_rptr <= r_rptr + PTR_ONE;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_FULL);
      r_empty <= (w_count_nxt == '0);
      if (i_wr_en && r_full) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[r_wptr] <= i_wr_data;
  end

  assign o_rd_data  = r_mem[r_rptr];
  assign o_full     = r_full;
  assign o_empty    = r_empty;
  assign o_overflow = r_overflow;
endmodule

// File: rtl/shake_hand_send.sv
// rtl/shake_hand_send.sv - transmit side of the four-phase byte handshake link
module shake_hand_send
  import shake_hand_pkg::*;
#(
  parameter int DW    = DEFAULT_DW,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  shake_hand_send_if.master bus
);
  logic          r_ack_d1;
  logic          r_ack_d2;
  logic          w_ack_s;
  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_ready;
  logic          w_ready_nxt;
  logic          r_done;
  logic          w_done_nxt;
  logic [DW-1:0] r_dout;
  logic          w_pop;
  logic [DW-1:0] w_head;
  logic          w_full;
  logic          w_empty;
  logic          w_overflow;

  shake_hand_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_wr_en    (bus.wr_en),
    .i_wr_data  (bus.wr_data),
    .i_rd_en    (w_pop),
    .o_rd_data  (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_overflow (w_overflow)
  );

  assign w_ack_s = r_ack_d2;

  // Idle only pops once ack_s is high again, which enforces the return-to-zero phase.
  always_comb begin
    w_state_nxt = r_state;
    w_ready_nxt = 1'b0;
    w_done_nxt  = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty && w_ack_s) begin
          w_pop       = 1'b1;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        w_ready_nxt = 1'b1;
        w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (w_ack_s) begin
          w_ready_nxt = 1'b1;
        end else begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack_d1 <= 1'b0;
      r_ack_d2 <= 1'b0;
      r_state  <= S_IDLE;
      r_ready  <= 1'b0;
      r_done   <= 1'b0;
      r_dout   <= '0;
    end else begin
      r_ack_d1 <= bus.ack;
      r_ack_d2 <= r_ack_d1;
      r_state  <= w_state_nxt;
      r_ready  <= w_ready_nxt;
      r_done   <= w_done_nxt;
      if (w_pop) r_dout <= w_head;
    end
  end

  assign bus.ready    = r_ready;
  assign bus.dout     = r_dout;
  assign bus.done     = r_done;
  assign bus.full     = w_full;
  assign bus.empty    = w_empty;
  assign bus.overflow = w_overflow;
endmodule

// File: doc/shake_hand_send.md
Name: shake_hand_send

Overview:
- Transmit side of the byte-wide four-phase handshake link; sits directly upstream of the handshake receiver.
- Local logic pushes bytes into a small internal FIFO.
- The block presents each byte on dout, raises ready, and waits for the receiver's ack to fall, then rise again, before sending the next byte.
- ack arrives from the receiver and is treated as asynchronous, so it is double-flopped before use.

Parameters:
- DW, 8, data width of wr_data and dout.
- DEPTH, 4, FIFO depth in entries; power of two, at least 2.
- AW, 2, FIFO pointer width, log2(DEPTH).

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  push wr_data into the FIFO this cycle.
- wr_data  input  DW  byte to transmit.
- full  output  1  FIFO holds DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- overflow  output  1  sticky; set when wr_en is high while full; cleared only by reset.
- ack  input  1  receiver acknowledge: high = ready to accept, low = byte taken.
- ready  output  1  data-valid strobe to the receiver.
- dout  output  DW  byte presented to the receiver.
- done  output  1  one-cycle pulse when a byte's handshake completes.

Behaviour:
- Reset values: ready=0, dout=0, done=0, overflow=0, full=0, empty=1, FIFO pointers and count=0, ack_d1=ack_d2=0, state=S_IDLE. Asserting rst_n low at any point aborts a transfer in flight and drops ready asynchronously.
- Synchroniser: ack_d1<=ack, ack_d2<=ack_d1. The FSM uses only ack_s=ack_d2.
- FIFO write rules:
  - wr_en && !full: write at wptr, wptr++ (wraps mod DEPTH).
  - wr_en && full: data dropped, overflow<=1. A write is not accepted when full even if a pop happens in the same cycle.
  - Simultaneous write and pop (not full, not empty): count unchanged, both pointers advance.
  - Write when empty: the entry becomes poppable the following cycle.
- FSM:
  - S_IDLE: ready=0. If !empty && ack_s: pop, dout<=head, go to S_SETUP. Otherwise stay.
  - S_SETUP: ready<=1, go to S_HOLD. This gives one full cycle of dout setup before ready rises.
  - S_HOLD: ready held 1 and dout held stable. When ack_s==0: ready<=0, done<=1 for one cycle, go to S_IDLE.
- Next byte: S_IDLE will not pop again until ack_s returns high. This enforces the return-to-zero phase: the receiver must see ready low and re-raise ack first.
- Latency: with ack_s already high and the FIFO empty, a write at edge N gives the pop and dout valid at N+1, and ready=1 at N+2.
- dout changes only on a pop; it keeps its last value while idle.
- ack already low while in S_IDLE: no pop; the block waits indefinitely with no timeout.
- ack glitching high and low shorter than 2 cycles may be missed; this is legal, and the protocol tolerates it by waiting.
- full and empty are registered and derived from the count (width AW+1).

Decomposition:
- Package shake_hand_pkg:
  - state encoding: S_IDLE=2'b00, S_SETUP=2'b01, S_HOLD=2'b10;
  - default DW/DEPTH constants, shared with the receiver.
- Sub-module shake_hand_fifo:
  - synchronous FIFO, DW x DEPTH;
  - ports wr_en/wr_data/rd_en/rd_data/full/empty/overflow;
  - rd_data is the combinational head.
- Top level holds the synchroniser and the FSM only.

Test Plan:
- Reset then idle: rst_n low for 3 cycles with ack=1 -> ready=0, dout=0, empty=1, full=0, overflow=0, done never pulses.
- Single byte: ack tied 1, write 8'hA5 at edge N -> dout=8'hA5 at N+1, ready=1 at N+2. Drop ack -> ready falls exactly 3 edges after ack falls, done pulses once.
- Back-to-back: write 8'h11,8'h22,8'h33, loop ready to a receiver model that acks per protocol -> the receiver collects 11,22,33 in order with no duplicates. Between bytes ready stays low until ack_s has risen again.
- Full/overflow: with ack=0 write 5 bytes (DEPTH=4) -> full=1 after 4th write, 5th byte dropped, overflow=1 and stays 1. After ack=1 the 4 stored bytes drain, 5th never appears.
- Stall: byte pending, ack held 0 for 50 cycles -> no pop, ready=0, dout unchanged. Raise ack -> transfer proceeds with the normal latency.
- Reset mid-transfer: assert rst_n low while in S_HOLD with ready=1 -> ready drops immediately (asynchronous), FIFO empties. After release, new byte 8'h5A transfers correctly.
